wb_port_arbiter: RTL



---
 rtl/wb_port_arbiter_pkg.sv | 22 ++
 rtl/wb_ret_fifo.sv | 76 +++++++
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: data widths,
// the buffered miss-return entry and the grant-source encoding.
package wb_port_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One buffered miss return; live drops to 0 once a younger pipeline
  // write to the same register makes the data stale.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
    logic              live;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_BUF
  } gnt_src_e;

endpackage

// File: rtl/wb_ret_fifo.sv
// Miss-return buffer: a small circular FIFO whose entries carry a live bit
// that can be cleared in parallel by destination-register match.
module wb_ret_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      push,
  input  wb_port_arbiter_pkg::wb_entry_t            pushEntry,
  input  logic                                      pop,
  input  logic                                      killEn,
  input  logic [wb_port_arbiter_pkg::REG_AW-1:0]    killRd,
  output wb_port_arbiter_pkg::wb_entry_t            headEntry,
  output logic [$clog2(DEPTH+1)-1:0]                count
);
  import wb_port_arbiter_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [REG_AW-1:0] rdMem [DEPTH];
  logic [XLEN-1:0]   wdMem [DEPTH];
  logic [DEPTH-1:0]  liveMem;
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;

  // Head view; an empty buffer never presents a live head.
  always_comb begin
    headEntry.rd   = rdMem[rdPtr];
    headEntry.wd   = wdMem[rdPtr];
    headEntry.live = (count != '0) && liveMem[rdPtr];
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage for the buffered returns.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is deliberately not reset; an entry is only
    // ever read while count and its live bit say it is valid.
    if (push) begin
      rdMem[wrPtr] <= pushEntry.rd;
      wdMem[wrPtr] <= pushEntry.wd;
    end
  end

  // Live bits: reset, parallel kill by rd, then the incoming entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      liveMem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killEn && (rdMem[i] == killRd)) liveMem[i] <= 1'b0;
      end
      // The tail slot is unoccupied, so the pushed entry's own live value wins.
      if (push) liveMem[wrPtr] <= pushEntry.live;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, miss
// returns are buffered, a starved live head forces a one-cycle stall, and
// younger pipeline writes kill stale buffered returns.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = wb_port_arbiter_pkg::XLEN
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pipe_we_i,
  input  logic [wb_port_arbiter_pkg::REG_AW-1:0] pipe_rd_i,
  input  logic [XLEN-1:0]                        pipe_wd_i,
  input  logic                                   mem_valid_i,
  input  logic [wb_port_arbiter_pkg::REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]                        mem_wd_i,
  output logic                                   mem_ready_o,
  output logic                                   stall_o,
  output logic                                   rf_we_o,
  output logic [wb_port_arbiter_pkg::REG_AW-1:0] rf_rd_o,
  output logic [XLEN-1:0]                        rf_wd_o,
  output logic [$clog2(DEPTH+1)-1:0]             buf_count_o
);
  import wb_port_arbiter_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(MAX_WAIT+1);

  logic          pipeReq;
  logic          push;
  logic          pop;
  logic          killEn;
  logic [CW-1:0] count;
  logic [WW-1:0] waitCnt;
  wb_entry_t     pushEntry;
  wb_entry_t     headEntry;
  gnt_src_e      grant;

  wb_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .killEn    (killEn),
    .killRd    (pipe_rd_i),
    .headEntry (headEntry),
    .count     (count)
  );

  assign buf_count_o = count;

  // Request decode, stall and fixed-priority grant; all forced idle in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pipeReq     = pipe_we_i && (pipe_rd_i != '0);
    mem_ready_o = rst && (count < CW'(DEPTH));
    stall_o     = rst && pipeReq && headEntry.live && (waitCnt == WW'(MAX_WAIT));
    grant       = GNT_NONE;
    if (!rst)                grant = GNT_NONE;
    else if (stall_o)        grant = GNT_BUF;
    else if (pipeReq)        grant = GNT_PIPE;
    else if (count != '0)    grant = GNT_BUF;
  end

  // FIFO controls; a return aimed at x0 is accepted but dropped.
  always_comb begin
    pop            = (grant == GNT_BUF);
    killEn         = (grant == GNT_PIPE);
    push           = mem_valid_i && mem_ready_o && (mem_rd_i != '0);
    pushEntry.rd   = mem_rd_i;
    pushEntry.wd   = mem_wd_i;
    pushEntry.live = !(killEn && (pipe_rd_i == mem_rd_i));
  end

  // Register-file port mux; address and data are zero whenever no write occurs.
  always_comb begin
    rf_we_o = 1'b0;
    rf_rd_o = '0;
    rf_wd_o = '0;
    case (grant)
      GNT_PIPE: begin
        rf_we_o = 1'b1;
        rf_rd_o = pipe_rd_i;
        rf_wd_o = pipe_wd_i;
      end
      GNT_BUF: begin
        if (headEntry.live) begin
          rf_we_o = 1'b1;
          rf_rd_o = headEntry.rd;
          rf_wd_o = headEntry.wd;
        end
      end
      default: ;
    endcase
  end

  // Starvation counter for the live head, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (pop || !headEntry.live) begin
      waitCnt <= '0;
    end else if (waitCnt != WW'(MAX_WAIT)) begin
      waitCnt <= waitCnt + WW'(1);
    end
  end

endmodule
